// File: rtl/shifter8_seq_ctrl_if.sv
// Command/result bundle for the 8-bit shift sequencer.
// Requester drives the command side, sequencer drives q/busy/done.
interface shifter8_seq_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
);
   logic             start;
   logic [2:0]       op;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;

   modport master (
      output start, op, amt, d_in,
      input  q, busy, done
   );

   modport slave (
      input  start, op, amt, d_in,
      output q, busy, done
   );
endinterface

// File: rtl/shifter8_seq_ctrl.sv
// Multi-bit shift sequencer: loads an operand, then applies one
// 1-bit shift/rotate per clock until the latched amount runs out.
module shifter8_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   shifter8_seq_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic [2:0] OP_LSL = 3'd0;
   localparam logic [2:0] OP_LSR = 3'd1;
   localparam logic [2:0] OP_ASR = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;

   state_t           state;
   logic [2:0]       op_r;
   logic [AMT_W-1:0] cnt;
   logic [WIDTH-1:0] q_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] step;

   // One 1-bit step of the latched operation on the working value
   always_comb begin
      step = q_r;
      case (op_r)
         OP_LSL:  step = {q_r[WIDTH-2:0], 1'b0};
         OP_LSR:  step = {1'b0, q_r[WIDTH-1:1]};
         OP_ASR:  step = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
         OP_ROL:  step = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
         OP_ROR:  step = {q_r[0], q_r[WIDTH-1:1]};
         default: step = q_r;
      endcase
   end

   // Sequencer FSM; busy/done are registered alongside the state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         q_r    <= '0;
         op_r   <= '0;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  q_r    <= bus.d_in;
                  op_r   <= bus.op;
                  cnt    <= bus.amt;
                  busy_r <= 1'b1;
                  if (bus.amt != '0) begin
                     state  <= SHIFT;
                     done_r <= 1'b0;
                  end else begin
                     state  <= DONE;
                     done_r <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               q_r <= step;
               cnt <= cnt - 1'b1;
               if (cnt == AMT_W'(1)) begin
                  state  <= DONE;
                  done_r <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.q    = q_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

endmodule

// File: tb/tb_shifter8_seq_ctrl.sv
// Scoreboard bench for shifter8_seq_ctrl: directed cases plus
// random commands checked against a closed-form shift model.
module tb_shifter8_seq_ctrl;

   logic clk;
   logic reset_n;

   shifter8_seq_ctrl_if #(.WIDTH(8), .AMT_W(3)) bus ();

   shifter8_seq_ctrl #(.WIDTH(8), .AMT_W(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [7:0] q;
      int         amt;
   } exp_t;

   exp_t sb[$];
   int   tests;
   int   fails;
   int   run;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Result of n steps, computed in one go rather than step by step
   function automatic logic [7:0] model(input logic [7:0] d,
                                        input logic [2:0] o,
                                        input int n);
      logic [15:0] dd;
      logic [7:0]  r;
      dd = {d, d};
      case (o)
         3'd0: r = d << n;
         3'd1: r = d >> n;
         3'd2: r = 8'($signed(d) >>> n);
         3'd3: begin dd = dd << n; r = dd[15:8]; end
         3'd4: begin dd = dd >> n; r = dd[7:0]; end
         default: r = d;
      endcase
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the accept edge
   task automatic issue(input logic [7:0] d, input logic [2:0] o,
                        input int n, input bit expect_it);
      bus.d_in  = d;
      bus.op    = o;
      bus.amt   = 3'(n);
      bus.start = 1'b1;
      if (expect_it) sb.push_back('{model(d, o, n), n});
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (bus.done !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("wait_done", 32'(bus.done), 32'd1);
      @(negedge clk);
   endtask

   // Monitor: measures busy length and checks q at every done pulse
   initial begin
      exp_t e;
      run = 0;
      forever begin
         @(negedge clk);
         if (bus.busy === 1'b1) run++;
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("sb_q", 32'(bus.q), 32'(e.q));
               chk("sb_busy_len", 32'(run), 32'(e.amt + 1));
            end
         end
         if (bus.busy !== 1'b1) run = 0;
      end
   end

   initial begin
      int k;
      tests     = 0;
      fails     = 0;
      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.amt   = 3'd0;
      bus.d_in  = 8'h00;

      // 1: reset state, then idle with start low
      repeat (2) @(negedge clk);
      chk("rst_q", 32'(bus.q), 32'h00);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      reset_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("idle_q", 32'(bus.q), 32'h00);
         chk("idle_busy", 32'(bus.busy), 32'd0);
      end

      // 2: LSL by 3
      issue(8'h96, 3'd0, 3, 1'b1);
      wait_done();

      // 3: ASR by 2, watch each step and the hold afterwards
      issue(8'h90, 3'd2, 2, 1'b1);
      chk("asr_load", 32'(bus.q), 32'h90);
      @(negedge clk);
      chk("asr_step1", 32'(bus.q), 32'hC8);
      @(negedge clk);
      chk("asr_step2", 32'(bus.q), 32'hE4);
      chk("asr_done", 32'(bus.done), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("asr_hold", 32'(bus.q), 32'hE4);
         chk("asr_idle", 32'(bus.busy), 32'd0);
      end

      // 4: ROR by 7, then reload with ROL by 1
      issue(8'h81, 3'd4, 7, 1'b1);
      wait_done();
      chk("ror_result", 32'(bus.q), 32'h03);
      issue(8'h03, 3'd3, 1, 1'b1);
      wait_done();
      chk("rol_result", 32'(bus.q), 32'h06);

      // 5: zero amount
      issue(8'h5A, 3'd1, 0, 1'b1);
      chk("amt0_done", 32'(bus.done), 32'd1);
      chk("amt0_q", 32'(bus.q), 32'h5A);
      @(negedge clk);
      chk("amt0_busy_end", 32'(bus.busy), 32'd0);

      // Back-to-back with start held high
      bus.d_in  = 8'h3C;
      bus.op    = 3'd3;
      bus.amt   = 3'd4;
      bus.start = 1'b1;
      sb.push_back('{model(8'h3C, 3'd3, 4), 4});
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (bus.done !== 1'b1 && k < 20);
      chk("b2b_first_done", 32'(bus.done), 32'd1);
      bus.d_in = 8'hA5;
      bus.op   = 3'd2;
      bus.amt  = 3'd2;
      sb.push_back('{model(8'hA5, 3'd2, 2), 2});
      @(negedge clk);
      chk("b2b_gap", 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("b2b_reaccept", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      wait_done();

      // 6: ignored start mid-shift, then reset abandons the command
      issue(8'hFF, 3'd0, 5, 1'b0);
      chk("abort_load", 32'(bus.q), 32'hFF);
      bus.d_in  = 8'h00;
      bus.op    = 3'd5;
      bus.amt   = 3'd1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("abort_step1", 32'(bus.q), 32'hFE);
      @(negedge clk);
      chk("abort_step2", 32'(bus.q), 32'hFC);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_q", 32'(bus.q), 32'h00);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      reset_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("abort_no_done", 32'(bus.done), 32'd0);
      end

      // Random commands, all ops including HOLD codes
      for (int i = 0; i < 40; i++) begin
         issue(8'($urandom), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), 1'b1);
         wait_done();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
